// File: rtl/dpram_ctrl.sv
// Dual-port RAM controller: zero-fills the RAM after reset, registers the write
// port, and round-robin arbitrates two read clients with a tagged response pipeline.
module dpram_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 2,
  parameter int INIT_EN    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_done,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_req_addr,
  input  logic [DATA_WIDTH-1:0] wr_req_data,
  output logic                  wr_ready,
  input  logic [1:0]            rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_req_addr0,
  input  logic [ADDR_WIDTH-1:0] rd_req_addr1,
  output logic [1:0]            rd_gnt,
  output logic [1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_ecccorr,
  output logic                  rsp_eccderr,
  output logic [15:0]           corr_cnt,
  output logic [15:0]           derr_cnt,
  output logic                  wr_cs,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_cs,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  ecccorr,
  input  logic                  eccderr
);

  typedef enum logic {S_INIT, S_RUN} state_t;
  localparam state_t RST_STATE = (INIT_EN != 0) ? S_INIT : S_RUN;

  state_t              state, state_nxt;
  logic [ADDR_WIDTH:0] init_cnt;
  logic                init_full;
  logic                rr_last;
  logic [RD_LATENCY:0] vld_pipe;
  logic [RD_LATENCY:0] tag_pipe;

  // Extra MSB on the fill counter marks "every address has been written".
  assign init_full = init_cnt[ADDR_WIDTH];
  assign init_done = (state == S_RUN);
  assign rd_cs     = vld_pipe[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RST_STATE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_ready  = 1'b0;
    rd_gnt    = 2'b00;
    case (state)
      S_INIT: if (init_full) state_nxt = S_RUN;
      S_RUN: begin
        wr_ready = rst_n;
        if (rst_n) begin
          case (rd_req)
            2'b01:   rd_gnt = 2'b01;
            2'b10:   rd_gnt = 2'b10;
            // rr_last names the client granted most recently; the other one wins.
            2'b11:   rd_gnt = rr_last ? 2'b01 : 2'b10;
            default: rd_gnt = 2'b00;
          endcase
        end
      end
      default: state_nxt = RST_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt <= '0;
      wr_cs    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else if (state == S_INIT) begin
      wr_data <= '0;
      if (!init_full) begin
        wr_cs    <= 1'b1;
        wr_addr  <= init_cnt[ADDR_WIDTH-1:0];
        init_cnt <= init_cnt + (ADDR_WIDTH+1)'(1);
      end else begin
        wr_cs <= 1'b0;
      end
    end else begin
      wr_cs <= wr_req;
      if (wr_req) begin
        wr_addr <= wr_req_addr;
        wr_data <= wr_req_data;
      end
    end
  end

  // Stage 0 of the valid/tag pipe is the RAM read strobe itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
      rd_addr  <= '0;
      rr_last  <= 1'b1;
    end else begin
      vld_pipe <= {vld_pipe[RD_LATENCY-1:0], |rd_gnt};
      tag_pipe <= {tag_pipe[RD_LATENCY-1:0], rd_gnt[1]};
      if (|rd_gnt) begin
        rr_last <= rd_gnt[1];
        rd_addr <= rd_gnt[1] ? rd_req_addr1 : rd_req_addr0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid   <= 2'b00;
      rsp_data    <= '0;
      rsp_ecccorr <= 1'b0;
      rsp_eccderr <= 1'b0;
      corr_cnt    <= '0;
      derr_cnt    <= '0;
    end else if (vld_pipe[RD_LATENCY]) begin
      rsp_valid   <= tag_pipe[RD_LATENCY] ? 2'b10 : 2'b01;
      rsp_data    <= rd_data;
      rsp_ecccorr <= ecccorr;
      rsp_eccderr <= eccderr;
      if (ecccorr && corr_cnt != 16'hFFFF) corr_cnt <= corr_cnt + 16'd1;
      if (eccderr && derr_cnt != 16'hFFFF) derr_cnt <= derr_cnt + 16'd1;
    end else begin
      rsp_valid <= 2'b00;
    end
  end

endmodule

// File: tb/tb_dpram_ctrl.sv
// Bench for dpram_ctrl: behavioural RAM with fixed read latency plus a
// response scoreboard filled at grant time and drained on rsp_valid.
module tb_dpram_ctrl;
  localparam int AW  = 4;
  localparam int DW  = 8;
  localparam int RDL = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          init_done, wr_req, wr_ready, wr_cs, rd_cs;
  logic [AW-1:0] wr_req_addr, rd_req_addr0, rd_req_addr1, wr_addr, rd_addr;
  logic [DW-1:0] wr_req_data, rsp_data, wr_data, rd_data;
  logic [1:0]    rd_req, rd_gnt, rsp_valid;
  logic          rsp_ecccorr, rsp_eccderr, ecccorr, eccderr;
  logic [15:0]   corr_cnt, derr_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          client;
    logic [DW-1:0] data;
    logic        corr;
    logic        derr;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  logic [DW-1:0]   ref_mem [16];
  logic [DW-1:0]   mem [16] = '{default: 8'hEE};
  logic [15:0]     corr_f = 16'h0260;  // addresses 5, 6, 9 report corrected errors
  logic [15:0]     derr_f = 16'h0080;  // address 7 reports a double error
  logic [DW+1:0]   rpipe [RDL] = '{default: '0};

  dpram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(RDL), .INIT_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .wr_req(wr_req), .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_req_addr0(rd_req_addr0), .rd_req_addr1(rd_req_addr1), .rd_gnt(rd_gnt),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ecccorr(rsp_ecccorr), .rsp_eccderr(rsp_eccderr),
    .corr_cnt(corr_cnt), .derr_cnt(derr_cnt),
    .wr_cs(wr_cs), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_cs(rd_cs), .rd_addr(rd_addr), .rd_data(rd_data), .ecccorr(ecccorr), .eccderr(eccderr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM: rd_cs sampled at edge N -> data presented for sampling at edge N+RDL.
  always @(posedge clk) begin
    if (wr_cs) mem[wr_addr] <= wr_data;
    rpipe[0] <= {mem[rd_addr], corr_f[rd_addr], derr_f[rd_addr]};
    for (int k = 1; k < RDL; k++) rpipe[k] <= rpipe[k-1];
  end
  assign {rd_data, ecccorr, eccderr} = rpipe[RDL-1];

  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid !== 2'b00) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected: rsp_valid=%b with no outstanding read", rsp_valid);
      end else begin
        e = exp_q.pop_front();
        if (rsp_valid !== (2'b01 << e.client)) begin
          failures++; $display("FAIL rsp_client: rsp_valid=%b exp client %0d", rsp_valid, e.client);
        end
        checks++;
        if (rsp_data !== e.data) begin
          failures++; $display("FAIL rsp_data: got %h exp %h", rsp_data, e.data);
        end
        checks++;
        if ({rsp_ecccorr, rsp_eccderr} !== {e.corr, e.derr}) begin
          failures++; $display("FAIL rsp_ecc: got %b%b exp %b%b", rsp_ecccorr, rsp_eccderr, e.corr, e.derr);
        end
        checks++;
        if (cyc != e.due) begin
          failures++; $display("FAIL rsp_latency: arrived cycle %0d exp %0d", cyc, e.due);
        end
      end
    end
    if (rst_n && !init_done) begin
      checks++;
      if (rd_cs !== 1'b0) begin
        failures++; $display("FAIL rd_cs_in_init: got %b exp 0", rd_cs);
      end
    end
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (rd_req[i] && rd_gnt[i]) begin
          logic [AW-1:0] a;
          a = (i == 0) ? rd_req_addr0 : rd_req_addr1;
          exp_q.push_back('{i, ref_mem[a], corr_f[a], derr_f[a], cyc + 2 + RDL});
        end
      end
    end
  end

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL %s_drain: outstanding=%0d exp 0", name, exp_q.size());
    end
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk); #1;
    wr_req = 1'b1; wr_req_addr = a; wr_req_data = d;
    @(posedge clk); #1;
    wr_req = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic test_reset;
    rd_req = 2'b11; wr_req = 1'b1; wr_req_addr = 4'd3; wr_req_data = 8'hFF;
    repeat (2) @(negedge clk);
    checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL reset_init_done: got %b exp 0", init_done); end
    checks++; if ({wr_cs, rd_cs} !== 2'b00) begin failures++; $display("FAIL reset_cs: got %b exp 00", {wr_cs, rd_cs}); end
    checks++; if ({rd_gnt, wr_ready} !== 3'b000) begin failures++; $display("FAIL reset_gnt_ready: got %b exp 000", {rd_gnt, wr_ready}); end
    checks++; if ({wr_addr, rd_addr, wr_data} !== '0) begin failures++; $display("FAIL reset_addr_data: got %h exp 0", {wr_addr, rd_addr, wr_data}); end
    checks++; if ({rsp_valid, rsp_data, rsp_ecccorr, rsp_eccderr} !== '0) begin failures++; $display("FAIL reset_rsp: got %h exp 0", {rsp_valid, rsp_data, rsp_ecccorr, rsp_eccderr}); end
    checks++; if ({corr_cnt, derr_cnt} !== 32'd0) begin failures++; $display("FAIL reset_cnt: got %h exp 0", {corr_cnt, derr_cnt}); end
  endtask

  task automatic test_init;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    rd_req_addr0 = 4'd0; rd_req_addr1 = 4'd0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (wr_cs !== 1'b0) begin failures++; $display("FAIL init_cycle0_wr_cs: got %b exp 0", wr_cs); end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks++;
      if ({wr_cs, wr_addr, wr_data} !== {1'b1, 4'(k), 8'h00} || {init_done, wr_ready, rd_gnt} !== 4'b0000) begin
        failures++;
        $display("FAIL init_fill[%0d]: cs=%b addr=%0d data=%h done=%b rdy=%b gnt=%b exp 1/%0d/00/0/0/00",
                 k, wr_cs, wr_addr, wr_data, init_done, wr_ready, rd_gnt, k);
      end
    end
    @(posedge clk); #1 wr_req = 1'b0;
    @(negedge clk);
    checks++; if ({init_done, wr_cs, wr_ready} !== 3'b101) begin failures++; $display("FAIL init_done_rise: done/cs/rdy got %b exp 101", {init_done, wr_cs, wr_ready}); end
    checks++; if (rd_gnt !== 2'b01) begin failures++; $display("FAIL rr_reset_ptr: got %b exp 01", rd_gnt); end
    @(posedge clk); #1 rd_req = 2'b00;
    drain("init");
  endtask

  task automatic test_write_read;
    @(posedge clk); #1;
    wr_req = 1'b1; wr_req_addr = 4'd3; wr_req_data = 8'hA5;
    @(negedge clk);
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL wr_ready_run: got %b exp 1", wr_ready); end
    @(posedge clk); #1;
    wr_req = 1'b0; ref_mem[3] = 8'hA5;
    rd_req = 2'b10; rd_req_addr1 = 4'd3;
    @(negedge clk);
    checks++; if ({wr_cs, wr_addr, wr_data} !== {1'b1, 4'd3, 8'hA5}) begin failures++; $display("FAIL wr_port: got %b/%0d/%h exp 1/3/a5", wr_cs, wr_addr, wr_data); end
    checks++; if (rd_gnt !== 2'b10) begin failures++; $display("FAIL single_gnt: got %b exp 10", rd_gnt); end
    @(posedge clk); #1 rd_req = 2'b00;
    @(negedge clk);
    checks++; if ({rd_cs, rd_addr} !== {1'b1, 4'd3}) begin failures++; $display("FAIL rd_port: got %b/%0d exp 1/3", rd_cs, rd_addr); end
    repeat (2) @(negedge clk);
    checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL rsp_early: got %b exp 00", rsp_valid); end
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_data} !== {2'b10, 8'hA5}) begin failures++; $display("FAIL wr_rd_rsp: got %b/%h exp 10/a5", rsp_valid, rsp_data); end
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_data} !== {2'b00, 8'hA5}) begin failures++; $display("FAIL rsp_hold: got %b/%h exp 00/a5", rsp_valid, rsp_data); end
  endtask

  task automatic test_rr;
    write_word(4'd1, 8'h11);
    write_word(4'd2, 8'h22);
    rd_req = 2'b11; rd_req_addr0 = 4'd1; rd_req_addr1 = 4'd2;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (rd_gnt !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
        failures++; $display("FAIL rr_gnt[%0d]: got %b exp %b", k, rd_gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
      end
    end
    @(posedge clk); #1 rd_req = 2'b00;
    drain("rr");
  endtask

  task automatic test_ecc;
    int cl [4] = '{0, 1, 0, 1};
    logic [AW-1:0] ad [4] = '{4'd5, 4'd6, 4'd5, 4'd7};
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      rd_req = 2'b01 << cl[k];
      if (cl[k] == 0) rd_req_addr0 = ad[k]; else rd_req_addr1 = ad[k];
    end
    @(posedge clk); #1 rd_req = 2'b00;
    drain("ecc");
    checks++; if (corr_cnt !== 16'd3) begin failures++; $display("FAIL ecc_corr_cnt: got %0d exp 3", corr_cnt); end
    checks++; if (derr_cnt !== 16'd1) begin failures++; $display("FAIL ecc_derr_cnt: got %0d exp 1", derr_cnt); end
  endtask

  task automatic test_saturate;
    @(posedge clk); #1;
    rd_req = 2'b01; rd_req_addr0 = 4'd9;
    repeat (65536) @(posedge clk);
    #1 rd_req = 2'b00;
    drain("sat");
    checks++; if (corr_cnt !== 16'hFFFF) begin failures++; $display("FAIL corr_saturate: got %h exp ffff", corr_cnt); end
    checks++; if (derr_cnt !== 16'd1) begin failures++; $display("FAIL derr_after_sat: got %0d exp 1", derr_cnt); end
  endtask

  task automatic test_reset_inflight;
    int n = 0;
    @(posedge clk); #1 rd_req = 2'b01; rd_req_addr0 = 4'd1;
    @(posedge clk); #1 rd_req = 2'b10; rd_req_addr1 = 4'd2;
    @(posedge clk); #1 rd_req = 2'b00; rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks++; if ({rsp_valid, rd_cs, init_done, corr_cnt, derr_cnt} !== '0) begin failures++; $display("FAIL rst_inflight_state: got %h exp 0", {rsp_valid, rd_cs, init_done, corr_cnt, derr_cnt}); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({wr_cs, wr_addr, rsp_valid} !== {1'b1, 4'(k), 2'b00}) begin
        failures++; $display("FAIL rst_fill1[%0d]: cs=%b addr=%0d rsp_valid=%b exp 1/%0d/00", k, wr_cs, wr_addr, rsp_valid, k);
      end
    end
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    checks++; if ({wr_cs, wr_addr} !== 5'd0) begin failures++; $display("FAIL rst_mid_init: got %b/%0d exp 0/0", wr_cs, wr_addr); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({wr_cs, wr_addr} !== {1'b1, 4'(k)}) begin
        failures++; $display("FAIL rst_refill[%0d]: cs=%b addr=%0d exp 1/%0d", k, wr_cs, wr_addr, k);
      end
    end
    while (init_done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++; if (init_done !== 1'b1) begin failures++; $display("FAIL rst_refill_done: init_done got %b exp 1", init_done); end
    checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL rst_no_rsp: got %b exp 00", rsp_valid); end
  endtask

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; wr_req = 1'b0; wr_req_addr = '0; wr_req_data = '0;
    rd_req = 2'b00; rd_req_addr0 = '0; rd_req_addr1 = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'hEE;
    test_reset;
    test_init;
    test_write_read;
    test_rr;
    test_ecc;
    test_saturate;
    test_reset_inflight;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dpram_ctrl.md
DPRAM_CTRL -- requirements
Module: dpram_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, RAM address width.
REQ-002 Parameter DATA_WIDTH, default 8, RAM data width.
REQ-003 Parameter RD_LATENCY, default 2, RAM read latency in cycles: rd_cs high at edge N gives rd_data valid at edge N+RD_LATENCY; legal range 1..8.
REQ-004 Parameter INIT_EN, default 1, enables the zero-fill sequence after reset.
REQ-005 Ports (name, direction, width, meaning):
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- init_done  out  1  zero-fill complete, controller in RUN.
- wr_req  in  1  write client request.
- wr_req_addr  in  ADDR_WIDTH  write client address.
- wr_req_data  in  DATA_WIDTH  write client data.
- wr_ready  out  1  write accepted when wr_req && wr_ready.
- rd_req  in  2  read client requests, bit i = client i.
- rd_req_addr0 / rd_req_addr1  in  ADDR_WIDTH each  read client addresses.
- rd_gnt  out  2  one-hot-or-zero grant; read accepted when rd_req[i] && rd_gnt[i].
- rsp_valid  out  2  one-hot-or-zero response strobe per client.
- rsp_data  out  DATA_WIDTH  response data.
- rsp_ecccorr / rsp_eccderr  out  1 each  forwarded ECC flags, qualified by rsp_valid.
- corr_cnt  out  16  saturating count of ecccorr responses.
- derr_cnt  out  16  saturating count of eccderr responses.
- wr_cs, wr_addr, wr_data  out  1/ADDR_WIDTH/DATA_WIDTH  RAM write port.
- rd_cs, rd_addr  out  1/ADDR_WIDTH  RAM read port.
- rd_data  in  DATA_WIDTH; ecccorr, eccderr  in  1 each  RAM read return.

Function
REQ-006 Two states, INIT and RUN; reset enters INIT if INIT_EN=1, else RUN.
REQ-007 INIT: wr_cs=1, wr_data=0, wr_addr increments by 1 per cycle from 0 to 2^ADDR_WIDTH-1; RUN entered on the cycle after the last address is written; wr_ready=0 and rd_gnt=0 throughout INIT.
REQ-008 init_done=1 exactly when state is RUN.
REQ-009 RUN write path: wr_ready=1; wr_cs/wr_addr/wr_data registered from wr_req/wr_req_addr/wr_req_data (1-cycle latency).
REQ-010 RUN read arbitration: rd_gnt is combinational from rd_req and a round-robin pointer; single requester is granted immediately; on contention the client not granted last wins; the pointer updates only on a granted transfer.
REQ-011 Pointer reset value selects client 0 as first winner on contention.
REQ-012 rd_cs/rd_addr registered: granted transfer in cycle T drives rd_cs=1 with that address in cycle T+1; rd_cs=0 otherwise.
REQ-013 Client tag travels in a RD_LATENCY-deep valid/tag pipeline alongside each rd_cs; one read may issue every cycle (fully pipelined, no back-pressure on responses).
REQ-014 rd_data/ecccorr/eccderr sampled at the edge where the tag exits the pipeline and registered: response for rd_cs in cycle T+1 appears with rsp_valid[tag]=1 in cycle T+2+RD_LATENCY, for one cycle.
REQ-015 rsp_data/rsp_ecccorr/rsp_eccderr hold their last value when rsp_valid=0.
REQ-016 corr_cnt/derr_cnt increment by 1 on each response with the respective flag set, saturating at 16'hFFFF; both flags set in one response increment both.
REQ-017 No read/write address hazard checking: a same-address read and write are both issued; resulting data is defined by the RAM.

Reset
REQ-018 rst_n low asynchronously forces: state to INIT (INIT_EN=1) or RUN, init address counter 0, round-robin pointer to client 0, valid pipeline cleared, wr_cs=0, rd_cs=0, wr_addr/rd_addr/wr_data=0, rsp_valid=0, rsp_data=0, rsp ECC flags 0, corr_cnt=derr_cnt=0, init_done=0 (INIT_EN=1).
REQ-019 Reset mid-INIT restarts the fill from address 0; reset with reads in flight discards them, and no rsp_valid pulse is emitted for them.
REQ-020 Outputs are driven from registers except rd_gnt and wr_ready, which are 0 while rst_n is low.

Verification
REQ-021 ADDR_WIDTH=4, INIT_EN=1, release reset -> wr_cs high 16 cycles, addresses 0..15, data 0; init_done rises on the 17th cycle; no rd_gnt before then.
REQ-022 RUN, write addr 3 = 8'hA5, then client 1 reads addr 3, RD_LATENCY=2, RAM model returns 8'hA5 -> rsp_valid=2'b10 with rsp_data=8'hA5 exactly 4 cycles after the grant cycle.
REQ-023 Both clients request continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; rsp_valid follows the same order, one per cycle.
REQ-024 RAM model asserts ecccorr on 3 responses and eccderr on 1 -> corr_cnt=3, derr_cnt=1; with corr_cnt preloaded via 65536 flagged responses -> holds at 16'hFFFF.
REQ-025 Assert rst_n low with 2 reads in flight and mid-INIT -> no rsp_valid after reset; fill restarts at address 0.
REQ-026 Attach dpram_intf_checker to the RAM ports with rd_delay_cycle=RD_LATENCY -> zero checker errors across all scenarios above.
